// File: rtl/id_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// id_issue_scoreboard
//   Issue controller for the instruction-decode stage. Tracks in-flight
//   destination registers, outstanding loads and unresolved branches and
//   decides each cycle whether the instruction in ID issues or stalls.
//   This block is the only source of the ID stall signal.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_*_i          decoded instruction in ID (register usage, class flags)
//   ex_ready_i      execute stage can accept an instruction this cycle
//   wb_*_i          writeback of a register (and whether it completes a load)
//   br_resolve_i    the outstanding branch has resolved
//   issue_o         ID issues this cycle (combinational)
//   stall_o         ID holds a valid instruction that does not issue
//   exc_o           sticky undefined-instruction exception (registered)
//   busy_o          any pending register or outstanding load
//   ld_cnt_o        outstanding load count
// ---------------------------------------------------------------------------
module id_issue_scoreboard #(
    parameter int N_REG  = 32,
    parameter int W_REG  = 5,
    parameter int MAX_LD = 4,
    parameter int W_LDC  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [W_REG-1:0] id_rs1_i,
    input  logic             id_rs1_use_i,
    input  logic [W_REG-1:0] id_rs2_i,
    input  logic             id_rs2_use_i,
    input  logic [W_REG-1:0] id_rd_i,
    input  logic             id_rd_we_i,
    input  logic             id_ld_i,
    input  logic             id_br_i,
    input  logic             id_und_i,
    input  logic             ex_ready_i,
    input  logic             wb_valid_i,
    input  logic [W_REG-1:0] wb_rd_i,
    input  logic             wb_ld_i,
    input  logic             br_resolve_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             exc_o,
    output logic             busy_o,
    output logic [W_LDC-1:0] ld_cnt_o
);

    typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_t;

    state_t           state;
    logic [N_REG-1:0] pending;
    logic [N_REG-1:0] pend_eff;
    logic [N_REG-1:0] pending_nxt;
    logic [W_LDC-1:0] ld_cnt;
    logic             raw, waw, ldfull;
    logic             ld_inc, ld_dec;

    // A register written back this cycle no longer blocks issue this cycle.
    always_comb begin
        pend_eff = pending;
        if (wb_valid_i) pend_eff[wb_rd_i] = 1'b0;
    end

    // Register 0 never hazards: it is excluded explicitly and also never set.
    assign raw    = (id_rs1_use_i && (id_rs1_i != '0) && pend_eff[id_rs1_i]) ||
                    (id_rs2_use_i && (id_rs2_i != '0) && pend_eff[id_rs2_i]);
    assign waw    = id_rd_we_i && (id_rd_i != '0) && pend_eff[id_rd_i];
    assign ldfull = id_ld_i && (ld_cnt == W_LDC'(MAX_LD));

    assign issue_o = id_valid_i && (state == RUN) && !id_und_i && ex_ready_i &&
                     !raw && !waw && !ldfull;
    assign stall_o = id_valid_i && !issue_o;

    // Clear from writeback first, then set from issue so a same-register
    // collision leaves the new producer pending.
    always_comb begin
        pending_nxt = pend_eff;
        if (issue_o && id_rd_we_i && (id_rd_i != '0)) pending_nxt[id_rd_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    assign ld_inc = issue_o && id_ld_i;
    assign ld_dec = wb_valid_i && wb_ld_i;

    assign busy_o   = (|pending) || (ld_cnt != '0);
    assign ld_cnt_o = ld_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pending <= '0;
            ld_cnt  <= '0;
            exc_o   <= 1'b0;
        end else begin
            pending <= pending_nxt;

            // Simultaneous issue and completion cancel; ldfull keeps the
            // increment from exceeding MAX_LD, and 0 absorbs a stray decrement.
            if (ld_inc && !ld_dec)
                ld_cnt <= ld_cnt + W_LDC'(1);
            else if (!ld_inc && ld_dec && (ld_cnt != '0))
                ld_cnt <= ld_cnt - W_LDC'(1);

            case (state)
                RUN: begin
                    if (id_valid_i && id_und_i) begin
                        state <= HALT;
                        exc_o <= 1'b1;
                    end else if (issue_o && id_br_i) begin
                        state <= BR_WAIT;
                    end
                end
                BR_WAIT: if (br_resolve_i) state <= RUN;
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
module tb_id_issue_scoreboard;

    localparam int W_REG = 5;
    localparam int W_LDC = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid_i;
    logic [W_REG-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic             id_rs1_use_i, id_rs2_use_i, id_rd_we_i;
    logic             id_ld_i, id_br_i, id_und_i;
    logic             ex_ready_i;
    logic             wb_valid_i;
    logic [W_REG-1:0] wb_rd_i;
    logic             wb_ld_i;
    logic             br_resolve_i;
    logic             issue_o, stall_o, exc_o, busy_o;
    logic [W_LDC-1:0] ld_cnt_o;

    id_issue_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs1_use_i(id_rs1_use_i),
        .id_rs2_i(id_rs2_i), .id_rs2_use_i(id_rs2_use_i),
        .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
        .id_ld_i(id_ld_i), .id_br_i(id_br_i), .id_und_i(id_und_i),
        .ex_ready_i(ex_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_ld_i(wb_ld_i),
        .br_resolve_i(br_resolve_i),
        .issue_o(issue_o), .stall_o(stall_o), .exc_o(exc_o),
        .busy_o(busy_o), .ld_cnt_o(ld_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  issue, stall, exc, busy;
        int    ldc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
        id_rs1_use_i = 0; id_rs2_use_i = 0; id_rd_we_i = 0;
        id_ld_i = 0; id_br_i = 0; id_und_i = 0; ex_ready_i = 1;
        wb_valid_i = 0; wb_rd_i = 0; wb_ld_i = 0; br_resolve_i = 0;
    endtask

    task automatic ins(input int rd, input int rs1, input int rs2,
                       input bit ld = 0, input bit br = 0, input bit und = 0);
        id_valid_i = 1;
        id_rd_i = W_REG'(rd);  id_rd_we_i = 1;
        id_rs1_i = W_REG'(rs1); id_rs1_use_i = 1;
        id_rs2_i = W_REG'(rs2); id_rs2_use_i = 1;
        id_ld_i = ld; id_br_i = br; id_und_i = und;
    endtask

    task automatic wb(input int rd, input bit ld = 0);
        wb_valid_i = 1; wb_rd_i = W_REG'(rd); wb_ld_i = ld;
    endtask

    // Push the expectation for the inputs currently driven, then advance a cycle.
    task automatic cyc(input string tag, input bit ei, input bit es,
                       input bit ee, input bit eb, input int el);
        exp_t e;
        e.tag = tag; e.issue = ei; e.stall = es; e.exc = ee; e.busy = eb; e.ldc = el;
        q.push_back(e);
        @(negedge clk);
        idle();
    endtask

    // Outputs are sampled 4 time units after inputs change, before the posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".issue"}, issue_o, e.issue);
                chk({e.tag, ".stall"}, stall_o, e.stall);
                chk({e.tag, ".exc"},   exc_o,   e.exc);
                chk({e.tag, ".busy"},  busy_o,  e.busy);
                chk({e.tag, ".ldc"},   int'(ld_cnt_o), e.ldc);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        idle(); rst = 1; cyc("rst0", 0, 0, 0, 0, 0);
        rst = 1;         cyc("rst1", 0, 0, 0, 0, 0);
        rst = 0;

        // back-to-back independent ALU ops
        ins(3, 1, 2);            cyc("alu1", 1, 0, 0, 0, 0);
        ins(4, 5, 6);            cyc("alu2", 1, 0, 0, 1, 0);
        // RAW on r3, then writeback bypass
        ins(10, 3, 0);           cyc("raw3", 0, 1, 0, 1, 0);
        ins(10, 3, 0); wb(3);    cyc("byp3", 1, 0, 0, 1, 0);
        ins(7, 1, 2);            cyc("alu7", 1, 0, 0, 1, 0);
        ins(8, 7, 1);            cyc("raw7", 0, 1, 0, 1, 0);
        ins(8, 7, 1); wb(7);     cyc("byp7", 1, 0, 0, 1, 0);
        wb(4);                   cyc("drn4", 0, 0, 0, 1, 0);
        wb(10);                  cyc("drn10", 0, 0, 0, 1, 0);
        wb(8);                   cyc("drn8", 0, 0, 0, 1, 0);
                                 cyc("empty", 0, 0, 0, 0, 0);
        // load limit
        for (int i = 0; i < 4; i++) begin
            ins(12 + i, 1, 0, 1);
            cyc($sformatf("ld%0d", i), 1, 0, 0, i != 0, i);
        end
        ins(16, 1, 0, 1);             cyc("ldfull", 0, 1, 0, 1, 4);
        ins(16, 1, 0, 1); wb(12, 1);  cyc("ldfull_wb", 0, 1, 0, 1, 4);
        ins(16, 1, 0, 1);             cyc("ld5", 1, 0, 0, 1, 3);
        wb(14, 1);                    cyc("ldwb14", 0, 0, 0, 1, 4);
        ins(17, 1, 0, 1); wb(15, 1);  cyc("ld_and_wb", 1, 0, 0, 1, 3);
        wb(16, 1);                    cyc("ldkeep", 0, 0, 0, 1, 3);
        wb(17, 1);                    cyc("lddrn2", 0, 0, 0, 1, 2);
        wb(13, 1);                    cyc("lddrn1", 0, 0, 0, 1, 1);
                                      cyc("lddone", 0, 0, 0, 0, 0);
        // branch with link, wait for resolve
        ins(1, 2, 0, 0, 1);           cyc("br", 1, 0, 0, 0, 0);
        ins(5, 6, 7);                 cyc("brw1", 0, 1, 0, 1, 0);
        ins(5, 6, 7);                 cyc("brw2", 0, 1, 0, 1, 0);
        ins(5, 6, 7); br_resolve_i = 1; cyc("brres", 0, 1, 0, 1, 0);
        ins(5, 6, 7);                 cyc("brgo", 1, 0, 0, 1, 0);
        wb(1); br_resolve_i = 1;      cyc("resrun", 0, 0, 0, 1, 0);
        ins(6, 0, 0); wb(5);          cyc("afterres", 1, 0, 0, 1, 0);
        // r0 never pending, never a hazard
        ins(0, 0, 0);                 cyc("r0w", 1, 0, 0, 1, 0);
        wb(6);                        cyc("drn6", 0, 0, 0, 1, 0);
                                      cyc("r0idle", 0, 0, 0, 0, 0);
        // WAW on r9, same-cycle wb + reissue keeps it pending
        ins(9, 1, 2);                 cyc("w9a", 1, 0, 0, 0, 0);
        ins(9, 2, 3);                 cyc("waw9", 0, 1, 0, 1, 0);
        ins(9, 2, 3); wb(9);          cyc("waw9wb", 1, 0, 0, 1, 0);
                                      cyc("p9held", 0, 0, 0, 1, 0);
        wb(9);                        cyc("drn9", 0, 0, 0, 1, 0);
                                      cyc("p9clr", 0, 0, 0, 0, 0);
        ins(2, 1, 1); ex_ready_i = 0; cyc("exbusy", 0, 1, 0, 0, 0);
        // undefined opcode -> HALT until reset
        ins(3, 1, 2, 0, 0, 1);        cyc("und", 0, 1, 0, 0, 0);
        ins(3, 1, 2);                 cyc("halt1", 0, 1, 1, 0, 0);
        ins(3, 1, 2); br_resolve_i = 1; cyc("halt2", 0, 1, 1, 0, 0);
        rst = 1;                      cyc("rstm", 0, 0, 1, 0, 0);
        rst = 0;
        ins(3, 1, 2);                 cyc("post", 1, 0, 0, 0, 0);
                                      cyc("postbusy", 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("queue_empty", q.size(), 0);
        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
